// File: rtl/pixel_seq_pkg.sv
// Shared types and sizing helpers for the pixel-array frame sequencer.
// The default state encoding and parameter values live here so the top and bench agree.
package pixel_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    CONVERT = 3'd3,
    READ    = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_ERASE_CYCLES = 5;
  localparam int DEF_N_ROWS       = 2;
  localparam int DEF_READ_CYCLES  = 3;
  localparam int DEF_EXP_W        = 16;

  // Bits needed to hold the value v (at least one).
  function automatic int bits_for(input int v);
    int b;
    b = $clog2(v + 1);
    return (b < 1) ? 1 : b;
  endfunction

  // The timer must hold the longest phase length minus one without overflow.
  function automatic int timer_width(input int exp_w, input int width,
                                     input int erase_cycles, input int read_cycles);
    int w;
    w = exp_w;
    if (width + 1 > w) w = width + 1;
    if (bits_for(erase_cycles) > w) w = bits_for(erase_cycles);
    if (bits_for(read_cycles) > w) w = bits_for(read_cycles);
    return w;
  endfunction

endpackage

// File: rtl/pixel_frame_sequencer_phase_timer.sv
// Loadable down-counter used to time each sequencer phase.
// Holds at zero until reloaded; zero flag is decoded from the stored count.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Frame controller for the pixel-array ADC: erase, expose, convert (Graycounter sweep), readout.
// Optional back-to-back frames are enabled by defining PIXEL_SEQ_CONTINUOUS_EN.
module pixel_frame_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
  parameter int N_ROWS       = DEF_N_ROWS,
  parameter int READ_CYCLES  = DEF_READ_CYCLES,
  parameter int EXP_W        = DEF_EXP_W,
  localparam int ROW_W       = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [EXP_W-1:0] expose_time,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic             counter_reset,
  output logic             read,
  output logic [ROW_W-1:0] read_row,
  output logic             busy,
  output logic             done
);

  localparam int TW = timer_width(EXP_W, WIDTH, ERASE_CYCLES, READ_CYCLES);

  localparam logic [TW-1:0]    ERASE_LOAD   = TW'(ERASE_CYCLES - 1);
  localparam logic [TW-1:0]    CONVERT_LOAD = TW'((2 ** WIDTH) - 1);
  localparam logic [TW-1:0]    READ_LOAD    = TW'(READ_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(N_ROWS - 1);

  seq_state_t       state_q, state_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [ROW_W-1:0] read_row_q, read_row_d;

  logic             erase_q, erase_d;
  logic             expose_q, expose_d;
  logic             convert_q, convert_d;
  logic             counter_reset_q, counter_reset_d;
  logic             read_q, read_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             timer_load;
  logic [TW-1:0]    timer_value;
  logic             timer_zero;
  logic [TW-1:0]    expose_load;

  phase_timer #(
    .W(TW)
  ) u_phase_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .zero      (timer_zero)
  );

  // A zero exposure still produces one expose cycle.
  assign expose_load = (exp_q == '0) ? '0 : (TW'(exp_q) - TW'(1));

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    read_row_d  = read_row_q;
    timer_load  = 1'b0;
    timer_value = '0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = ERASE;
          exp_d       = expose_time;
          timer_load  = 1'b1;
          timer_value = ERASE_LOAD;
        end
      end
      ERASE: begin
        if (timer_zero) begin
          state_d     = EXPOSE;
          timer_load  = 1'b1;
          timer_value = expose_load;
        end
      end
      EXPOSE: begin
        if (timer_zero) begin
          state_d     = CONVERT;
          timer_load  = 1'b1;
          timer_value = CONVERT_LOAD;
        end
      end
      CONVERT: begin
        if (timer_zero) begin
          state_d     = READ;
          read_row_d  = '0;
          timer_load  = 1'b1;
          timer_value = READ_LOAD;
        end
      end
      READ: begin
        if (timer_zero) begin
          if (read_row_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            read_row_d  = read_row_q + ROW_W'(1);
            timer_load  = 1'b1;
            timer_value = READ_LOAD;
          end
        end
      end
      DONE: begin
`ifdef PIXEL_SEQ_CONTINUOUS_EN
        if (start && !abort) begin
          state_d     = ERASE;
          exp_d       = expose_time;
          timer_load  = 1'b1;
          timer_value = ERASE_LOAD;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every phase transition; the latched exposure is left alone.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      timer_load  = 1'b1;
      timer_value = '0;
    end

    if (state_d != READ) begin
      read_row_d = '0;
    end
  end

  always_comb begin
    erase_d         = (state_d == ERASE);
    expose_d        = (state_d == EXPOSE);
    convert_d       = (state_d == CONVERT);
    counter_reset_d = (state_d != CONVERT);
    read_d          = (state_d == READ);
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      exp_q           <= '0;
      read_row_q      <= '0;
      erase_q         <= 1'b0;
      expose_q        <= 1'b0;
      convert_q       <= 1'b0;
      counter_reset_q <= 1'b1;
      read_q          <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      exp_q           <= exp_d;
      read_row_q      <= read_row_d;
      erase_q         <= erase_d;
      expose_q        <= expose_d;
      convert_q       <= convert_d;
      counter_reset_q <= counter_reset_d;
      read_q          <= read_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign erase         = erase_q;
  assign expose        = expose_q;
  assign convert       = convert_q;
  assign counter_reset = counter_reset_q;
  assign read          = read_q;
  assign read_row      = read_row_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer with default parameters.
// Cycle n is the period following start-sampling edge n-1; outputs are sampled 1 ns after each edge.
module tb_pixel_frame_sequencer;

  localparam int ERASE_CYCLES = 5;
  localparam int READ_CYCLES  = 3;
  localparam int N_ROWS       = 2;
  localparam int CONV_CYCLES  = 256;
  localparam logic [7:0] IDLE_VEC = 8'b0001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] expose_time = 16'd0;

  logic erase, expose, convert, counter_reset, read, busy, done;
  logic [0:0] read_row;
  logic [7:0] obs;
  logic [7:0] gc_count;

  int checks = 0;
  int errors = 0;

  pixel_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .expose_time  (expose_time),
    .erase        (erase),
    .expose       (expose),
    .convert      (convert),
    .counter_reset(counter_reset),
    .read         (read),
    .read_row     (read_row),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Stand-in for the Graycounter, reporting its decoded (binary) value.
  always @(posedge clk) begin
    if (counter_reset) gc_count <= 8'd0;
    else gc_count <= gc_count + 8'd1;
  end

  assign obs = {erase, expose, convert, counter_reset, read, read_row, busy, done};

  // Expected outputs in cycle c of a frame whose start was sampled at edge 0.
  function automatic logic [7:0] exp_vec(input int c, input int e);
    int ee, xs, cs, rs, ds;
    logic er, ex, cv, rd, rw, bz, dn;
    ee = (e == 0) ? 1 : e;
    xs = 1 + ERASE_CYCLES;
    cs = xs + ee;
    rs = cs + CONV_CYCLES;
    ds = rs + N_ROWS * READ_CYCLES;
    er = (c >= 1) && (c < xs);
    ex = (c >= xs) && (c < cs);
    cv = (c >= cs) && (c < rs);
    rd = (c >= rs) && (c < ds);
    rw = rd ? 1'((c - rs) / READ_CYCLES) : 1'b0;
    bz = (c >= 1) && (c <= ds);
    dn = (c == ds);
    return {er, ex, cv, ~cv, rd, rw, bz, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    expose_time = 16'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== IDLE_VEC) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: got %b expected %b", i, obs, IDLE_VEC);
      end
    end
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== IDLE_VEC) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", i, obs, IDLE_VEC);
      end
    end
  endtask

  task automatic test_nominal();
    expose_time = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 280; c++) begin
      checks++;
      if (obs !== exp_vec(c, 10)) begin
        errors++;
        $display("[TB] FAIL nominal cycle %0d: got %b expected %b", c, obs, exp_vec(c, 10));
      end
      if (c == 16 || c == 271) begin
        checks++;
        if (gc_count !== ((c == 16) ? 8'd0 : 8'd255)) begin
          errors++;
          $display("[TB] FAIL gray_sweep cycle %0d: got %0d expected %0d", c, gc_count,
                   (c == 16) ? 0 : 255);
        end
      end
      tick();
    end
  endtask

  task automatic test_zero_expose();
    int expose_cycles;
    expose_cycles = 0;
    expose_time = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 270; c++) begin
      checks++;
      if (obs !== exp_vec(c, 0)) begin
        errors++;
        $display("[TB] FAIL zero_expose cycle %0d: got %b expected %b", c, obs, exp_vec(c, 0));
      end
      if (expose) expose_cycles++;
      if (c == 7) begin
        checks++;
        if (convert !== 1'b1) begin
          errors++;
          $display("[TB] FAIL zero_expose_convert_start: got %b expected 1", convert);
        end
      end
      tick();
    end
    checks++;
    if (expose_cycles != 1) begin
      errors++;
      $display("[TB] FAIL zero_expose_length: got %0d expected 1", expose_cycles);
    end
  endtask

  task automatic test_abort();
    expose_time = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      checks++;
      if (obs !== exp_vec(c, 10)) begin
        errors++;
        $display("[TB] FAIL abort_pre cycle %0d: got %b expected %b", c, obs, exp_vec(c, 10));
      end
      if (c == 100) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    for (int c = 101; c <= 104; c++) begin
      checks++;
      if (obs !== IDLE_VEC) begin
        errors++;
        $display("[TB] FAIL abort_idle cycle %0d: got %b expected %b", c, obs, IDLE_VEC);
      end
      tick();
    end
    expose_time = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 276; c++) begin
      checks++;
      if (obs !== exp_vec(c, 7)) begin
        errors++;
        $display("[TB] FAIL abort_restart cycle %0d: got %b expected %b", c, obs, exp_vec(c, 7));
      end
      tick();
    end
  endtask

  task automatic test_ignored_start();
    expose_time = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 281; c++) begin
      checks++;
      if (obs !== exp_vec(c, 10)) begin
        errors++;
        $display("[TB] FAIL ignored_start cycle %0d: got %b expected %b", c, obs, exp_vec(c, 10));
      end
      if (c == 50) start = 1'b1;
      if (c == 51) start = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    expose_time = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 267; c++) begin
      checks++;
      if (obs !== exp_vec(c, 3)) begin
        errors++;
        $display("[TB] FAIL reset_mid_pre cycle %0d: got %b expected %b", c, obs, exp_vec(c, 3));
      end
      if (c == 267) begin
        reset = 1'b0;
        start = 1'b1;
        abort = 1'b1;
      end
      tick();
    end
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int c = 268; c <= 271; c++) begin
      checks++;
      if (obs !== IDLE_VEC) begin
        errors++;
        $display("[TB] FAIL reset_mid_after cycle %0d: got %b expected %b", c, obs, IDLE_VEC);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    expose_time = 16'd10;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 278; c++) begin
      checks++;
      if (obs !== exp_vec(c, 10)) begin
        errors++;
        $display("[TB] FAIL b2b_first cycle %0d: got %b expected %b", c, obs, exp_vec(c, 10));
      end
      tick();
    end
`ifdef PIXEL_SEQ_CONTINUOUS_EN
    for (int c = 279; c <= 290; c++) begin
      checks++;
      if (obs !== exp_vec(c - 278, 10)) begin
        errors++;
        $display("[TB] FAIL b2b_second cycle %0d: got %b expected %b", c, obs,
                 exp_vec(c - 278, 10));
      end
      tick();
    end
`else
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("[TB] FAIL b2b_idle_gap cycle 279: got %b expected %b", obs, IDLE_VEC);
    end
    tick();
    checks++;
    if (obs !== exp_vec(1, 10)) begin
      errors++;
      $display("[TB] FAIL b2b_restart cycle 280: got %b expected %b", obs, exp_vec(1, 10));
    end
`endif
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("[TB] FAIL b2b_cleanup: got %b expected %b", obs, IDLE_VEC);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_zero_expose();
    test_abort();
    test_ignored_start();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
